mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the Memory stage of the 5-stage RISC-V pipeline and controls the Memory/WriteBack pipeline register around them. It drives a valid/ready request channel and a response channel to data memory, and stalls the upstream pipeline while an access is outstanding. It enables or bubbles the M->W register and returns lane-aligned, sign/zero-extended load data for the W-stage result mux.

Parameters:
XLEN, 32, data/address width (only 32 supported)
STORE_ACK, 1, 1 = stores wait for drsp_valid; 0 = store completes on request acceptance
TIMEOUT_CYCLES, 256, cycles in REQ+RESP before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemReadM  in  1  M-stage instruction is a load
MemWriteM  in  1  M-stage instruction is a store
funct3M  in  3  access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU)
ALUResultM  in  32  effective address
WriteDataM  in  32  store data (unshifted)
dreq_valid  out  1  request valid
dreq_ready  in  1  memory accepts request
dreq_we  out  1  1 = write
dreq_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dreq_be  out  4  byte enables
dreq_wdata  out  32  lane-shifted store data
drsp_valid  in  1  response valid
drsp_rdata  in  32  response word
stall_o  out  1  freeze PC and F/D, D/E, E/M registers
mw_en_o  out  1  M->W register load enable
mw_flush_o  out  1  load a bubble (RegWrite=0) into M->W
RdataM  out  32  aligned, extended load data
misalign_err_o  out  1  one-cycle misaligned-access pulse
bus_err_o  out  1  one-cycle timeout pulse (0 unless MEM_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; dreq_valid=0, dreq_we=0, dreq_addr=0, dreq_be=0, dreq_wdata=0, RdataM=0, stall_o=0, mw_en_o=1, mw_flush_o=0, both error pulses 0, timeout counter 0. Reset mid-access aborts immediately to IDLE; late drsp_valid is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no memory op: stall_o=0, mw_en_o=1, mw_flush_o=0. The instruction passes through with zero added latency.
- IDLE, memory op, aligned: stall_o=1, mw_flush_o=1. Request fields are registered and the FSM moves to REQ. dreq_valid rises the next cycle.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned op: no bus request. misalign_err_o=1 for one cycle, mw_flush_o=1, stall_o=0, FSM stays IDLE, instruction dropped.
- REQ: dreq_valid=1; all request fields stay stable until dreq_ready. On valid&&ready:
  - load -> RESP;
  - store with STORE_ACK=1 -> RESP;
  - store with STORE_ACK=0 -> DONE.
- RESP: dreq_valid=0. On drsp_valid, a load captures extended data into RdataM; then -> DONE. A drsp_valid seen in IDLE, REQ or DONE is ignored.
- stall_o=1 and mw_flush_o=1 throughout REQ and RESP, so W receives bubbles, not duplicates.
- DONE (exactly one cycle): stall_o=0, mw_en_o=1, mw_flush_o=0, RdataM valid; then -> IDLE.
- Minimum load latency: 3 stall cycles (IDLE->REQ->RESP->DONE) with ready and response each arriving in one cycle.
- Store lanes: SB be=1<<addr[1:0], data replicated per byte; SH be=0011 or 1100, data replicated per half; SW be=1111.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. funct3 011/110/111 are treated as LW.
- mw_en_o is 1 in every state; bubbles are produced via mw_flush_o.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on entering REQ and increments each cycle in REQ/RESP. On reaching TIMEOUT_CYCLES-1 without completion, the access aborts: dreq_valid=0, bus_err_o=1 for one cycle, mw_flush_o=1, stall_o=0, -> IDLE. The access completes normally if the completing event arrives in that same cycle.
- Undefined: no counter is present, the FSM waits indefinitely, and bus_err_o is tied 0.

Test Plan:
- ALU-only stream, MemRead/MemWrite=0 -> stall_o=0, mw_flush_o=0 every cycle, no dreq_valid.
- LB addr 0x1003, memory word 0x80FF_1234, ready and response each after 1 cycle -> 3 stall cycles; in DONE, RdataM=0xFFFF_FF80, mw_flush_o=0.
- SH addr 0x2002, data 0x0000_BEEF, STORE_ACK=1, dreq_ready held low 4 cycles -> request fields stable for 4 cycles; be=1100, wdata=0xBEEF_BEEF, dreq_addr=0x2000.
- LW addr 0x3001 -> misalign_err_o=1 for 1 cycle, no dreq_valid, mw_flush_o=1, stall_o=0.
- rst_n low while in RESP, then drsp_valid one cycle after release -> outputs at reset values, FSM IDLE, RdataM stays 0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, dreq_ready stuck low -> bus_err_o pulses on the 16th cycle after entering REQ, stall_o drops, FSM back in IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-memory access sequencer and M->W pipeline register control.
// Define MEM_TIMEOUT_EN to abort accesses that stay in REQ/RESP for TIMEOUT_CYCLES cycles.
module mem_access_ctrl #(
    parameter int XLEN           = 32,
    parameter bit STORE_ACK      = 1'b1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            dreq_valid,
    input  logic            dreq_ready,
    output logic            dreq_we,
    output logic [XLEN-1:0] dreq_addr,
    output logic [3:0]      dreq_be,
    output logic [XLEN-1:0] dreq_wdata,
    input  logic            drsp_valid,
    input  logic [XLEN-1:0] drsp_rdata,
    output logic            stall_o,
    output logic            mw_en_o,
    output logic            mw_flush_o,
    output logic [XLEN-1:0] RdataM,
    output logic            misalign_err_o,
    output logic            bus_err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      f3_q, f3_d;

    logic            mem_op, is_byte, is_half, misaligned;
    logic            timeout_hit;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new, ld_ext;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign mem_op     = MemReadM | MemWriteM;
    assign is_byte    = (funct3M[1:0] == 2'b00);
    assign is_half    = (funct3M[1:0] == 2'b01);
    assign misaligned = (is_half & ALUResultM[0]) | (~is_byte & ~is_half & (|ALUResultM[1:0]));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
        if (is_byte) begin
            be_new    = 4'b0001 << ALUResultM[1:0];
            wdata_new = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{WriteDataM[15:0]}};
        end
    end

    // Funct3 encodings other than byte/half all load the full word.
    always_comb begin
        ld_byte = drsp_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? drsp_rdata[31:16] : drsp_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_ext = f3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = f3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = drsp_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d       = (state_q == REQ || state_q == RESP) ? cnt_q + 1'b1 : '0;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // Request channel: dreq_valid is a pure function of state and never waits on
    // dreq_ready; a transfer happens on any cycle with dreq_valid && dreq_ready, and
    // all request fields are registers that only change while in IDLE.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        off_d          = off_q;
        f3_d           = f3_q;
        rdata_d        = rdata_q;
        stall_o        = 1'b0;
        mw_flush_o     = 1'b0;
        misalign_err_o = 1'b0;
        bus_err_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    mw_flush_o = 1'b1;
                    if (misaligned) begin
                        misalign_err_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        off_d   = ALUResultM[1:0];
                        f3_d    = funct3M;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                mw_flush_o = 1'b1;
                if (dreq_ready) begin
                    state_d = (we_q && !STORE_ACK) ? DONE : RESP;
                end else if (timeout_hit) begin
                    stall_o   = 1'b0;
                    bus_err_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            RESP: begin
                stall_o    = 1'b1;
                mw_flush_o = 1'b1;
                if (drsp_valid) begin
                    if (!we_q) rdata_d = ld_ext;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    stall_o   = 1'b0;
                    bus_err_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
        end
    end

    // An aborted request is withdrawn from the cycle after the timeout pulse.
    assign dreq_valid = (state_q == REQ);
    assign dreq_we    = we_q;
    assign dreq_addr  = addr_q;
    assign dreq_be    = be_q;
    assign dreq_wdata = wdata_q;
    assign RdataM     = rdata_q;
    assign mw_en_o    = 1'b1;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed loads/stores, misaligned ops, reset abort.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = '0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic        dreq_valid, dreq_ready = 1'b0, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_be;
    logic        drsp_valid = 1'b0;
    logic [31:0] drsp_rdata = '0;
    logic        stall_o, mw_en_o, mw_flush_o, misalign_err_o, bus_err_o;
    logic [31:0] RdataM;

    int tests_run = 0;
    int failures  = 0;

    logic [68:0] exp_req_q[$];
    logic [39:0] exp_done_q[$];
    logic [1:0]  exp_mis_q[$];
    logic [31:0] model_rdata = '0;

    logic [68:0] req_e;
    logic [39:0] done_e;
    logic [1:0]  mis_e;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0, prev_vnr = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_be = '0;

    mem_access_ctrl #(.XLEN(32), .STORE_ACK(1'b1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_be(dreq_be), .dreq_wdata(dreq_wdata),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
        .stall_o(stall_o), .mw_en_o(mw_en_o), .mw_flush_o(mw_flush_o),
        .RdataM(RdataM), .misalign_err_o(misalign_err_o), .bus_err_o(bus_err_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests_run++;
        failures++;
        $display("FAIL %s: DUT output with empty expected queue", name);
    endtask

    // monitor: pops the scoreboard queues whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt  = 0;
            prev_stall = 1'b0;
            prev_vnr   = 1'b0;
        end else begin
            if (dreq_valid && dreq_ready) begin
                if (exp_req_q.size() == 0) unexpected("req_unexpected");
                else begin
                    req_e = exp_req_q.pop_front();
                    check("req_we", dreq_we, req_e[68]);
                    check("req_addr", dreq_addr, req_e[67:36]);
                    if (req_e[68]) begin
                        check("req_be", dreq_be, req_e[35:32]);
                        check("req_wdata", dreq_wdata, req_e[31:0]);
                    end
                end
            end
            if (dreq_valid && prev_vnr) begin
                check("hold_we", dreq_we, prev_we);
                check("hold_addr", dreq_addr, prev_addr);
                check("hold_be", dreq_be, prev_be);
                check("hold_wdata", dreq_wdata, prev_wdata);
            end
            prev_vnr   = dreq_valid && !dreq_ready;
            prev_we    = dreq_we;
            prev_addr  = dreq_addr;
            prev_be    = dreq_be;
            prev_wdata = dreq_wdata;

            if (misalign_err_o) begin
                if (exp_mis_q.size() == 0) unexpected("mis_unexpected");
                else begin
                    mis_e = exp_mis_q.pop_front();
                    check("mis_stall_flush", {stall_o, mw_flush_o}, mis_e);
                    check("mis_no_req", dreq_valid, 1'b0);
                end
            end

            if (stall_o) stall_cnt++;
            else begin
                if (prev_stall && !mw_flush_o && !bus_err_o) begin
                    if (exp_done_q.size() == 0) unexpected("done_unexpected");
                    else begin
                        done_e = exp_done_q.pop_front();
                        check("done_rdata", RdataM, done_e[39:8]);
                        check("done_stalls", stall_cnt, done_e[7:0]);
                        check("done_mw_en", mw_en_o, 1'b1);
                    end
                end
                stall_cnt = 0;
            end
            prev_stall = stall_o;
        end
    end

    // driver tasks
    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic clear_inputs();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic send_req(input int rdy, output logic ok);
        int n = 0;
        while (!dreq_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = dreq_valid;
        check("req_seen", dreq_valid, 1'b1);
        if (ok) begin
            repeat (rdy) begin @(posedge clk); #1; end
            dreq_ready = 1'b1;
            @(posedge clk); #1;
            dreq_ready = 1'b0;
        end
    endtask

    task automatic send_rsp(input logic [31:0] rword, input int rsp);
        repeat (rsp) begin @(posedge clk); #1; end
        drsp_valid = 1'b1;
        drsp_rdata = rword;
        @(posedge clk); #1;
        drsp_valid = 1'b0;
        drsp_rdata = '0;
    endtask

    task automatic run_vec(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                           input int rdy, input int rsp, input logic mis,
                           input logic [3:0] e_be, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        logic ok;
        if (mis) begin
            exp_mis_q.push_back(2'b01);
            @(posedge clk); #1;
            drive(rd, wr, f3, addr, wd);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            check("mis_pulse_len", misalign_err_o, 1'b0);
            check("mis_after_no_req", dreq_valid, 1'b0);
        end else begin
            exp_req_q.push_back({wr, addr[31:2], 2'b00, e_be, e_wdata});
            if (!wr) model_rdata = e_rdata;
            exp_done_q.push_back({model_rdata, 8'(3 + rdy + rsp)});
            @(posedge clk); #1;
            drive(rd, wr, f3, addr, wd);
            send_req(rdy, ok);
            if (ok) send_rsp(rword, rsp);
            @(posedge clk); #1;
            clear_inputs();
        end
    endtask

    initial begin
        logic ok;
        int   n;
        logic found;

        // reset values
        @(negedge clk);
        check("rst_dreq_valid", dreq_valid, 1'b0);
        check("rst_dreq_we", dreq_we, 1'b0);
        check("rst_dreq_addr", dreq_addr, 32'h0);
        check("rst_dreq_be", dreq_be, 4'h0);
        check("rst_dreq_wdata", dreq_wdata, 32'h0);
        check("rst_rdata", RdataM, 32'h0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_mw_en", mw_en_o, 1'b1);
        check("rst_flush", mw_flush_o, 1'b0);
        check("rst_errs", {misalign_err_o, bus_err_o}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU-only stream
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            funct3M    = 3'($urandom_range(0, 7));
            @(negedge clk);
            check("alu_stall", stall_o, 1'b0);
            check("alu_flush", mw_flush_o, 1'b0);
            check("alu_mw_en", mw_en_o, 1'b1);
            check("alu_no_req", dreq_valid, 1'b0);
        end
        clear_inputs();

        // loads: rd wr f3 addr wdata rword rdy rsp mis be wdata rdata
        run_vec(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
        run_vec(1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 1, 2, 0, 4'h0, 32'h0, 32'h0000_0080);
        run_vec(1, 0, 3'b000, 32'h1001, 32'h0, 32'h80FF_1234, 0, 0, 0, 4'h0, 32'h0, 32'h0000_0012);
        run_vec(1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF_1234, 0, 1, 0, 4'h0, 32'h0, 32'hFFFF_80FF);
        run_vec(1, 0, 3'b101, 32'h1000, 32'h0, 32'h80FF_1234, 2, 0, 0, 4'h0, 32'h0, 32'h0000_1234);
        run_vec(1, 0, 3'b010, 32'h1000, 32'h0, 32'h80FF_1234, 0, 0, 0, 4'h0, 32'h0, 32'h80FF_1234);
        run_vec(1, 0, 3'b110, 32'h1004, 32'h0, 32'h8000_0001, 0, 0, 0, 4'h0, 32'h0, 32'h8000_0001);
        run_vec(1, 0, 3'b001, 32'h1000, 32'h0, 32'h0000_8001, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF_8001);
        run_vec(1, 0, 3'b101, 32'h1002, 32'h0, 32'hF00D_0000, 0, 0, 0, 4'h0, 32'h0, 32'h0000_F00D);
        run_vec(1, 0, 3'b000, 32'h1000, 32'h0, 32'h0000_007F, 0, 0, 0, 4'h0, 32'h0, 32'h0000_007F);

        // stores (RdataM keeps the last load value)
        run_vec(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 4, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        run_vec(0, 1, 3'b000, 32'h2001, 32'h1234_56A5, 32'h0, 0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_vec(0, 1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 32'h0, 1, 1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_vec(0, 1, 3'b001, 32'h2000, 32'hFFFF_1357, 32'h0, 0, 0, 0, 4'b0011, 32'h1357_1357, 32'h0);
        run_vec(0, 1, 3'b000, 32'h2003, 32'h0000_005A, 32'h0, 0, 0, 0, 4'b1000, 32'h5A5A_5A5A, 32'h0);

        // misaligned
        run_vec(1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        run_vec(1, 0, 3'b001, 32'h3003, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        run_vec(0, 1, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        run_vec(0, 1, 3'b001, 32'h3001, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        run_vec(1, 0, 3'b101, 32'h3001, 32'h0, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0);

        // reset while in RESP, late response ignored
        @(posedge clk); #1;
        drive(1, 0, 3'b010, 32'h4000, 32'h0);
        exp_req_q.push_back({1'b0, 32'h4000, 4'h0, 32'h0});
        send_req(0, ok);
        rst_n = 1'b0;
        clear_inputs();
        model_rdata = '0;
        @(negedge clk);
        check("rstmid_stall", stall_o, 1'b0);
        check("rstmid_valid", dreq_valid, 1'b0);
        check("rstmid_rdata", RdataM, 32'h0);
        check("rstmid_addr", dreq_addr, 32'h0);
        check("rstmid_flush", mw_flush_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drsp_valid = 1'b1;
        drsp_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        check("late_rsp_rdata", RdataM, 32'h0);
        check("late_rsp_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        drsp_valid = 1'b0;
        drsp_rdata = '0;
        @(negedge clk);
        check("late_rsp_rdata2", RdataM, 32'h0);
        check("late_rsp_valid", dreq_valid, 1'b0);
        check("late_rsp_flush", mw_flush_o, 1'b0);

        // FSM must be usable again from IDLE
        run_vec(1, 0, 3'b010, 32'h1008, 32'h0, 32'h1357_9BDF, 0, 0, 0, 4'h0, 32'h0, 32'h1357_9BDF);

`ifdef MEM_TIMEOUT_EN
        // timeout with dreq_ready stuck low
        @(posedge clk); #1;
        drive(1, 0, 3'b010, 32'h5000, 32'h0);
        n = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            @(negedge clk);
            n++;
            if (bus_err_o) found = 1'b1;
        end
        check("to_seen", found, 1'b1);
        check("to_cycle", n, 17);
        check("to_stall", stall_o, 1'b0);
        check("to_flush", mw_flush_o, 1'b1);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("to_pulse_len", bus_err_o, 1'b0);
        check("to_idle_valid", dreq_valid, 1'b0);
        check("to_idle_stall", stall_o, 1'b0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("q_req_empty", exp_req_q.size(), 0);
        check("q_done_empty", exp_done_q.size(), 0);
        check("q_mis_empty", exp_mis_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
